uart_rx: RTL and testbench

- UART receiver; the receive-side counterpart of the team's uart_tx. Same frame format: 1 start bit, 8 data bits LSB first, optional even/odd parity, 1 stop bit.
- Samples rxd on an external oversampling strobe from the shared baud generator (OVERSAMPLE ticks per bit).
- Majority-votes each bit, then presents the byte with a one-cycle rx_ok pulse plus parity and framing error flags to the register/bus interface.

---
 rtl/uart_rx.sv | 138 +++++++++++++
 tb/tb_uart_rx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, oversampled 3-sample majority vote per bit,
// 8N1 or 8E1/8O1 frames, byte delivered with a one-cycle rx_ok and error flags.
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_sample,
  input  logic       rx_en,
  input  logic       no_parity,
  input  logic       ev_parity,
  input  logic       rxd,
  output logic [7:0] rxd_out,
  output logic       rx_ok,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_busy,
  output logic [2:0] dbg_state
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] MID_M1 = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] MID    = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] MID_P1 = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] LAST   = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state;
  logic            rxd_m, rxd_s;
  logic [TW-1:0]   tick_cnt;
  logic [2:0]      bit_cnt;
  logic            armed;
  logic            v0, v1;
  logic [7:0]      shreg;
  logic            par_bit;
  logic            cfg_no_par, cfg_ev;

  logic vote, tick_vote, tick_last;

  // vote combines the two stored samples with the live one at the MID+1 tick
  assign vote      = (v0 & v1) | (v0 & rxd_s) | (v1 & rxd_s);
  assign tick_vote = rx_sample && (tick_cnt == MID_P1);
  assign tick_last = rx_sample && (tick_cnt == LAST);
  assign rx_busy   = (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      armed      <= 1'b0;
      v0         <= 1'b0;
      v1         <= 1'b0;
      shreg      <= 8'h00;
      par_bit    <= 1'b0;
      cfg_no_par <= 1'b0;
      cfg_ev     <= 1'b0;
      rxd_out    <= 8'h00;
      rx_ok      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_ok <= 1'b0;
      if (!rx_en) begin
        state    <= IDLE;
        tick_cnt <= '0;
        bit_cnt  <= '0;
        if (state == IDLE && rxd_s) armed <= 1'b1;
      end else begin
        // tick_cnt is a power-of-two width, so LAST+1 wraps to 0 at each bit boundary
        if (state != IDLE && rx_sample) begin
          tick_cnt <= tick_cnt + TW'(1);
          if (tick_cnt == MID_M1) v0 <= rxd_s;
          if (tick_cnt == MID)    v1 <= rxd_s;
        end
        case (state)
          IDLE: begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            if (rxd_s) begin
              armed <= 1'b1;
            end else if (armed) begin
              state      <= START;
              cfg_no_par <= no_parity;
              cfg_ev     <= ev_parity;
              armed      <= 1'b0;
            end
          end
          START: begin
            if (tick_vote && vote) begin
              state    <= IDLE;
              tick_cnt <= '0;
            end else if (tick_last) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            if (tick_vote) shreg <= {vote, shreg[7:1]};
            if (tick_last) begin
              if (bit_cnt == 3'd7) state <= cfg_no_par ? STOP : PARITY;
              else bit_cnt <= bit_cnt + 3'd1;
            end
          end
          PARITY: begin
            if (tick_vote) par_bit <= vote;
            if (tick_last) state <= STOP;
          end
          STOP: begin
            // frame closes at mid-stop to leave margin for a back-to-back start bit
            if (tick_vote) begin
              rxd_out    <= shreg;
              rx_ok      <= 1'b1;
              frame_err  <= ~vote;
              parity_err <= cfg_no_par ? 1'b0 : (par_bit != ((^shreg) ^ ~cfg_ev));
              state      <= IDLE;
              tick_cnt   <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven bit by bit on the oversampling
// strobe, and a per-frame expectation queue is checked on every clock.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_sample = 1'b0;
  logic       rx_en = 1'b0;
  logic       no_parity = 1'b1;
  logic       ev_parity = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] rxd_out;
  logic       rx_ok, parity_err, frame_err, rx_busy;
  logic [2:0] dbg_state;

  int tests = 0;
  int fails = 0;
  int div = 4;
  int scnt = 0;
  logic [9:0] exp_q[$];
  logic [9:0] last_exp = 10'h000;
  logic       expect_idle = 1'b0;
  logic       busy_seen = 1'b0;

  uart_rx #(.OVERSAMPLE(16)) dut (
    .clk(clk), .rst(rst), .rx_sample(rx_sample), .rx_en(rx_en),
    .no_parity(no_parity), .ev_parity(ev_parity), .rxd(rxd),
    .rxd_out(rxd_out), .rx_ok(rx_ok), .parity_err(parity_err),
    .frame_err(frame_err), .rx_busy(rx_busy), .dbg_state(dbg_state)
  );

  // clock / reset / strobe
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      scnt++;
      rx_sample = (scnt % div == 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks: all line changes happen on the falling edge
  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk);
      if (rx_sample) k++;
    end
  endtask

  task automatic send_bit(input logic v);
    rxd = v;
    wait_ticks(16);
    @(negedge clk);
  endtask

  task automatic send_glitch_bit(input logic v);
    rxd = v;
    wait_ticks(8);
    @(negedge clk);
    rxd = ~v;
    wait_ticks(1);
    @(negedge clk);
    rxd = v;
    wait_ticks(7);
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_v, input logic stop_v,
                            input int glitch_bit);
    logic exp_par, perr;
    exp_par = ev_parity ? (^d) : ~(^d);
    perr    = no_parity ? 1'b0 : (par_v != exp_par);
    exp_q.push_back({~stop_v, perr, d});
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == glitch_bit) send_glitch_bit(d[i]);
      else send_bit(d[i]);
    end
    if (!no_parity) send_bit(par_v);
    send_bit(stop_v);
  endtask

  // scoreboard: each rx_ok consumes one expectation; outputs must hold otherwise
  always @(negedge clk) begin
    logic [9:0] e;
    if (!rst) begin
      if (rx_busy) busy_seen = 1'b1;
      if (rx_ok) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_rx_ok: got rxd_out=%0h expected no pulse at %0t", rxd_out, $time);
        end else begin
          e = exp_q.pop_front();
          chk("rx_data", 32'(rxd_out), 32'(e[7:0]));
          chk("rx_parity_err", 32'(parity_err), 32'(e[8]));
          chk("rx_frame_err", 32'(frame_err), 32'(e[9]));
          chk("rx_busy_at_ok", 32'(rx_busy), 32'd0);
          last_exp = e;
        end
      end else begin
        chk("hold_data", 32'(rxd_out), 32'(last_exp[7:0]));
        chk("hold_flags", 32'({frame_err, parity_err}), 32'(last_exp[9:8]));
      end
      if (expect_idle) chk("stay_idle", 32'(rx_busy), 32'd0);
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_data", 32'(rxd_out), 32'h00);
    chk("reset_flags", 32'({rx_ok, parity_err, frame_err, rx_busy}), 32'h0);
    rst   = 1'b0;
    rx_en = 1'b1;
    send_bit(1'b1);

    // 0xA5, no parity
    no_parity = 1'b1;
    send_frame(8'hA5, 1'b0, 1'b1, -1);
    chk("a5_data", 32'(rxd_out), 32'hA5);
    chk("a5_flags", 32'({parity_err, frame_err, rx_busy}), 32'h0);

    // 0x3C even parity bit 0, then odd config with the same parity bit
    no_parity = 1'b0;
    ev_parity = 1'b1;
    send_frame(8'h3C, 1'b0, 1'b1, -1);
    chk("3c_even_data", 32'(rxd_out), 32'h3C);
    chk("3c_even_perr", 32'(parity_err), 32'd0);
    ev_parity = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b1, -1);
    chk("3c_odd_data", 32'(rxd_out), 32'h3C);
    chk("3c_odd_perr", 32'(parity_err), 32'd1);

    // 4-tick low glitch in idle: false start
    busy_seen = 1'b0;
    rxd = 1'b0;
    wait_ticks(4);
    @(negedge clk);
    rxd = 1'b1;
    wait_ticks(20);
    @(negedge clk);
    chk("glitch_start_seen", 32'(busy_seen), 32'd1);
    chk("glitch_back_idle", 32'(rx_busy), 32'd0);
    chk("glitch_data_kept", 32'(rxd_out), 32'h3C);

    // 0x81 with bad stop, line held low, then a clean 0x55
    no_parity = 1'b1;
    send_frame(8'h81, 1'b0, 1'b0, -1);
    chk("81_data", 32'(rxd_out), 32'h81);
    chk("81_frame_err", 32'(frame_err), 32'd1);
    expect_idle = 1'b1;
    rxd = 1'b0;
    wait_ticks(48);
    @(negedge clk);
    send_bit(1'b1);
    expect_idle = 1'b0;
    send_frame(8'h55, 1'b0, 1'b1, -1);
    chk("55_data", 32'(rxd_out), 32'h55);
    chk("55_frame_err", 32'(frame_err), 32'd0);

    // rx_en dropped during data bit 4 of 0xF0
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    rxd = 1'b1;
    wait_ticks(8);
    @(negedge clk);
    rx_en = 1'b0;
    @(negedge clk);
    chk("en_drop_idle", 32'(rx_busy), 32'd0);
    expect_idle = 1'b1;
    wait_ticks(16);
    @(negedge clk);
    expect_idle = 1'b0;
    chk("en_drop_data_kept", 32'(rxd_out), 32'h55);
    rx_en = 1'b1;
    wait_ticks(4);
    @(negedge clk);
    send_frame(8'h0F, 1'b0, 1'b1, -1);
    chk("0f_data", 32'(rxd_out), 32'h0F);

    // back-to-back even-parity frames, one with a mid-bit glitch
    no_parity = 1'b0;
    ev_parity = 1'b1;
    send_frame(8'h12, 1'b0, 1'b1, -1);
    send_frame(8'h34, 1'b1, 1'b1, 2);
    chk("34_data", 32'(rxd_out), 32'h34);
    chk("34_flags", 32'({parity_err, frame_err}), 32'h0);

    // strobe held high continuously
    send_bit(1'b1);
    div = 1;
    send_bit(1'b1);
    send_frame(8'hC3, 1'b0, 1'b1, -1);
    send_bit(1'b1);
    chk("c3_fast_data", 32'(rxd_out), 32'hC3);
    chk("all_frames_delivered", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
